aes_byte_stream_host: RTL

- Host-side companion to the 8-bit serial AES-128 encryption core. It drives the core's byte inputs and collects its byte output.
- Accepts 16 key bytes, then 16 plaintext bytes, over a valid/ready byte stream and buffers them.
- Holds the core in reset while loading. It then releases the core and streams one key byte and one plaintext byte per clock during the core's 16-cycle load phase.
- Waits for the core's data-valid, captures 16 ciphertext bytes, and returns them over a valid/ready output stream with a last marker.

---
 rtl/aes_byte_stream_host.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_byte_stream_host.sv
// aes_byte_stream_host
// Host-side companion for an 8-bit serial AES-128 encryption core.
// Collects 16 key bytes and then 16 plaintext bytes from a valid/ready byte
// stream. It then releases the core from reset and feeds it one key byte and
// one plaintext byte per clock for 16 cycles. It waits for the core's sticky
// data-valid, captures 16 ciphertext bytes, and returns them over a
// valid/ready stream with a last marker.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active low
//   in_data      host byte (0-15 key, 16-31 plaintext, MSB-first)
//   in_valid     in_data valid
//   in_ready     byte accepted this cycle when in_valid is also high
//   core_rst     active-high reset to the AES core
//   core_key     key byte to the core
//   core_din     plaintext byte to the core
//   core_dout    ciphertext byte from the core
//   core_dvld    core data-valid (sticky until the core is reset)
//   out_data     ciphertext byte to the host
//   out_valid    out_data valid
//   out_ready    host accepts out_data
//   out_last     marks the 16th ciphertext byte
//   busy         high while streaming, waiting, capturing or draining
//   err_timeout  sticky; core never raised data-valid in time
module aes_byte_stream_host #(
  parameter int NBYTES      = 16,
  parameter int TIMEOUT_CYC = 4095,
  parameter int TO_W        = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       core_rst,
  output logic [7:0] core_key,
  output logic [7:0] core_din,
  input  logic [7:0] core_dout,
  input  logic       core_dvld,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       err_timeout
);

  typedef enum logic [2:0] {
    S_FILL,
    S_STREAM,
    S_WAIT,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  localparam logic [3:0] LAST_IDX   = 4'(NBYTES - 1);
  localparam logic [3:0] PRE_LAST   = 4'(NBYTES - 2);
  localparam logic [4:0] FILL_LAST  = 5'(2 * NBYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // Byte buffers, written through enables from the next-state logic.
  logic [7:0] key_buf [NBYTES];
  logic [7:0] pt_buf  [NBYTES];
  logic [7:0] ct_buf  [NBYTES];

  state_t          state_reg,    state_next;
  logic [4:0]      idx_reg,      idx_next;
  logic [TO_W-1:0] to_cnt_reg,   to_cnt_next;
  logic            core_rst_reg, core_rst_next;
  logic [7:0]      core_key_reg, core_key_next;
  logic [7:0]      core_din_reg, core_din_next;
  logic [7:0]      out_data_reg, out_data_next;
  logic            out_valid_reg, out_valid_next;
  logic            out_last_reg, out_last_next;
  logic            busy_reg,     busy_next;
  logic            err_reg,      err_next;

  logic key_we, pt_we, ct_we;
  logic accept;

  // Every read is one slot ahead of the current index: the registered output
  // must hold byte idx+1 after the edge that advances idx. The 4-bit wrap
  // makes the same address yield slot 0 when leaving FILL (idx 31) and when
  // leaving CAPTURE (idx 15).
  logic [3:0] rd_addr;
  assign rd_addr = idx_reg[3:0] + 4'd1;

  assign in_ready = (state_reg == S_FILL) && rst;
  assign accept   = in_valid && in_ready;

  // Key bytes land at idx 0-15 and plaintext at idx 16-31. So the low four
  // index bits are the slot in either buffer.
  always_ff @(posedge clk) begin
    if (key_we) key_buf[idx_reg[3:0]] <= in_data;
    if (pt_we)  pt_buf[idx_reg[3:0]]  <= in_data;
    if (ct_we)  ct_buf[idx_reg[3:0]]  <= core_dout;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= S_FILL;
      idx_reg       <= '0;
      to_cnt_reg    <= '0;
      core_rst_reg  <= 1'b1;
      core_key_reg  <= '0;
      core_din_reg  <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      to_cnt_reg    <= to_cnt_next;
      core_rst_reg  <= core_rst_next;
      core_key_reg  <= core_key_next;
      core_din_reg  <= core_din_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      busy_reg      <= busy_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    to_cnt_next    = to_cnt_reg;
    core_rst_next  = core_rst_reg;
    core_key_next  = core_key_reg;
    core_din_next  = core_din_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    err_next       = err_reg;
    key_we         = 1'b0;
    pt_we          = 1'b0;
    ct_we          = 1'b0;

    case (state_reg)
      S_FILL: begin
        core_rst_next = 1'b1;
        if (accept) begin
          err_next = 1'b0;
          key_we   = !idx_reg[4];
          pt_we    = idx_reg[4];
          if (idx_reg == FILL_LAST) begin
            // Release the core with byte 0 already on its inputs.
            state_next    = S_STREAM;
            idx_next      = '0;
            core_rst_next = 1'b0;
            core_key_next = key_buf[rd_addr];
            core_din_next = pt_buf[rd_addr];
          end else begin
            idx_next = idx_reg + 5'd1;
          end
        end
      end

      S_STREAM: begin
        if (idx_reg[3:0] == LAST_IDX) begin
          state_next    = S_WAIT;
          idx_next      = '0;
          to_cnt_next   = '0;
          core_key_next = '0;
          core_din_next = '0;
        end else begin
          idx_next      = idx_reg + 5'd1;
          core_key_next = key_buf[rd_addr];
          core_din_next = pt_buf[rd_addr];
        end
      end

      S_WAIT: begin
        to_cnt_next = to_cnt_reg + TO_W'(1);
        if (core_dvld) begin
          // The first valid cycle already carries ciphertext byte 0.
          ct_we      = 1'b1;
          idx_next   = 5'd1;
          state_next = S_CAPTURE;
        end else if (to_cnt_reg == TO_LAST) begin
          err_next      = 1'b1;
          core_rst_next = 1'b1;
          idx_next      = '0;
          state_next    = S_FILL;
        end
      end

      S_CAPTURE: begin
        ct_we = 1'b1;
        if (idx_reg[3:0] == LAST_IDX) begin
          state_next     = S_DRAIN;
          idx_next       = '0;
          core_rst_next  = 1'b1;
          out_valid_next = 1'b1;
          out_last_next  = 1'b0;
          out_data_next  = ct_buf[rd_addr];
        end else begin
          idx_next = idx_reg + 5'd1;
        end
      end

      S_DRAIN: begin
        if (out_ready) begin
          if (idx_reg[3:0] == LAST_IDX) begin
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            out_data_next  = '0;
            idx_next       = '0;
            state_next     = S_FILL;
          end else begin
            idx_next      = idx_reg + 5'd1;
            out_data_next = ct_buf[rd_addr];
            out_last_next = (idx_reg[3:0] == PRE_LAST);
          end
        end
      end

      default: begin
        state_next    = S_FILL;
        idx_next      = '0;
        core_rst_next = 1'b1;
      end
    endcase
  end

  // busy follows the registered state, so it drops the cycle after the final handshake.
  assign busy_next = (state_next != S_FILL);

  assign core_rst    = core_rst_reg;
  assign core_key    = core_key_reg;
  assign core_din    = core_din_reg;
  assign out_data    = out_data_reg;
  assign out_valid   = out_valid_reg;
  assign out_last    = out_last_reg;
  assign busy        = busy_reg;
  assign err_timeout = err_reg;

endmodule
